// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit-shifter command encoding, sequencer states and the
// register-access step table used by i2c_reg_ctrl.
package i2c_pkg;

    localparam int unsigned CMD_W  = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned TMO_W  = 24;
    localparam int unsigned TMO_CW = TMO_W + 1;

    localparam logic [CMD_W-1:0] CMD_WR   = 6'h01;
    localparam logic [CMD_W-1:0] CMD_STA  = 6'h02;
    localparam logic [CMD_W-1:0] CMD_RD   = 6'h04;
    localparam logic [CMD_W-1:0] CMD_STO  = 6'h08;
    localparam logic [CMD_W-1:0] CMD_ACK  = 6'h10;
    localparam logic [CMD_W-1:0] CMD_NACK = 6'h20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] tx;
        logic              last;
    } step_t;

    // 8-bit address mode skips the address-high step, so remap onto the 16-bit sequence
    function automatic step_t step_lookup(
        input logic              is_read,
        input logic              addr_mode,
        input logic [STEP_W-1:0] step,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wrdata,
        input logic [DATA_W-1:0] device_id
    );
        logic [STEP_W-1:0] idx;
        step_t             s;
        idx = (addr_mode || step == '0) ? step : STEP_W'(step + STEP_W'(1));
        s   = '{cmd: '0, tx: '0, last: 1'b1};
        case (idx)
            3'd0: s = '{cmd: CMD_STA | CMD_WR, tx: device_id & 8'hFE, last: 1'b0};
            3'd1: s = '{cmd: CMD_WR, tx: addr[15:8], last: 1'b0};
            3'd2: s = '{cmd: CMD_WR, tx: addr[7:0], last: 1'b0};
            3'd3: s = is_read ? '{cmd: CMD_STA | CMD_WR, tx: device_id | 8'h01, last: 1'b0}
                              : '{cmd: CMD_WR | CMD_STO, tx: wrdata, last: 1'b1};
            3'd4: s = '{cmd: CMD_RD | CMD_NACK | CMD_STO, tx: 8'h00, last: 1'b1};
            default: s = '{cmd: '0, tx: '0, last: 1'b1};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Register-level I2C master sequencer: expands one register write/read request into
// byte commands for i2c_bit_shift and reports read data, completion and ACK errors.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              wrreg_req,
    input  logic              rdreg_req,
    input  logic              addr_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrdata,
    input  logic [DATA_W-1:0] device_id,
    output logic [DATA_W-1:0] rddata,
    output logic              RW_Done,
    output logic              ack_err,
    output logic              busy,
    output logic [CMD_W-1:0]  Cmd,
    output logic              Go,
    output logic [DATA_W-1:0] Tx_DATA,
    input  logic [DATA_W-1:0] Rx_DATA,
    input  logic              Trans_Done,
    input  logic              ack_o
);

    logic [1:0]        state, state_nxt;
    logic [STEP_W-1:0] step_q, step_nxt;
    logic              is_read_q, mode_q, latch_en, is_read_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wrdata_q, id_q;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic              tmo_hit;

    logic [DATA_W-1:0] rddata_nxt, tx_nxt;
    logic [CMD_W-1:0]  cmd_nxt;
    logic              done_nxt, ack_nxt, busy_nxt, go_nxt;

    step_t first_step, cur_step, next_step;

    assign first_step = step_lookup(!wrreg_req, addr_mode, '0, addr, wrdata, device_id);
    assign cur_step   = step_lookup(is_read_q, mode_q, step_q, addr_q, wrdata_q, id_q);
    assign next_step  = step_lookup(is_read_q, mode_q, STEP_W'(step_q + STEP_W'(1)),
                                    addr_q, wrdata_q, id_q);

    // tmo_cnt counts cycles since Go (the Go cycle included)
    assign tmo_hit = (TIMEOUT_CYCLES != '0) &&
                     ((TMO_CW'(tmo_cnt) + TMO_CW'(1)) >= TMO_CW'(TIMEOUT_CYCLES));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        step_nxt    = step_q;
        latch_en    = 1'b0;
        is_read_nxt = is_read_q;
        tmo_cnt_nxt = tmo_cnt;
        rddata_nxt  = rddata;
        done_nxt    = 1'b0;
        ack_nxt     = ack_err;
        busy_nxt    = busy;
        cmd_nxt     = Cmd;
        go_nxt      = 1'b0;
        tx_nxt      = Tx_DATA;
        case (state)
            ST_IDLE: begin
                if (wrreg_req || rdreg_req) begin
                    state_nxt   = ST_ISSUE;
                    step_nxt    = '0;
                    latch_en    = 1'b1;
                    is_read_nxt = !wrreg_req;
                    busy_nxt    = 1'b1;
                    ack_nxt     = 1'b0;
                    go_nxt      = 1'b1;
                    cmd_nxt     = first_step.cmd;
                    tx_nxt      = first_step.tx;
                end
            end
            ST_ISSUE: begin
                state_nxt   = ST_WAIT;
                tmo_cnt_nxt = TMO_W'(1);
            end
            ST_WAIT: begin
                if (Trans_Done) begin
                    if ((cur_step.cmd & CMD_WR) != '0) ack_nxt = ack_err | ack_o;
                    if ((cur_step.cmd & CMD_RD) != '0) rddata_nxt = Rx_DATA;
                    if (cur_step.last) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        cmd_nxt   = '0;
                        tx_nxt    = '0;
                    end else begin
                        state_nxt = ST_ISSUE;
                        step_nxt  = STEP_W'(step_q + STEP_W'(1));
                        go_nxt    = 1'b1;
                        cmd_nxt   = next_step.cmd;
                        tx_nxt    = next_step.tx;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_DONE;
                    ack_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cmd_nxt   = '0;
                    tx_nxt    = '0;
                end else begin
                    tmo_cnt_nxt = TMO_W'(tmo_cnt + TMO_W'(1));
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            step_q    <= '0;
            is_read_q <= 1'b0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            wrdata_q  <= '0;
            id_q      <= '0;
            tmo_cnt   <= '0;
            rddata    <= '0;
            RW_Done   <= 1'b0;
            ack_err   <= 1'b0;
            busy      <= 1'b0;
            Cmd       <= '0;
            Go        <= 1'b0;
            Tx_DATA   <= '0;
        end else begin
            step_q    <= step_nxt;
            is_read_q <= is_read_nxt;
            if (latch_en) begin
                mode_q   <= addr_mode;
                addr_q   <= addr;
                wrdata_q <= wrdata;
                id_q     <= device_id;
            end
            tmo_cnt   <= tmo_cnt_nxt;
            rddata    <= rddata_nxt;
            RW_Done   <= done_nxt;
            ack_err   <= ack_nxt;
            busy      <= busy_nxt;
            Cmd       <= cmd_nxt;
            Go        <= go_nxt;
            Tx_DATA   <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with a behavioural byte-level bit-shifter/slave responder.
module tb_i2c_reg_ctrl;
    import i2c_pkg::*;

    localparam int LAT = 3;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        wrreg_req = 1'b0, rdreg_req = 1'b0, addr_mode = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wrdata = '0, device_id = '0;
    logic [7:0]  rddata, Tx_DATA;
    logic        RW_Done, ack_err, busy, Go;
    logic [5:0]  Cmd;
    logic [7:0]  Rx_DATA = '0;
    logic        Trans_Done = 1'b0, ack_o = 1'b0;

    int checks = 0;
    int errors = 0;

    i2c_reg_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
        .addr_mode(addr_mode), .addr(addr), .wrdata(wrdata), .device_id(device_id),
        .rddata(rddata), .RW_Done(RW_Done), .ack_err(ack_err), .busy(busy),
        .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA),
        .Trans_Done(Trans_Done), .ack_o(ack_o)
    );

    always #5 Clk = ~Clk;

    // responder state
    logic [13:0] log_q[$];
    int          td_cnt = 0, cur_idx = 0, nack_idx = -1;
    bit          resp_en = 1'b1;
    logic [7:0]  slave_rd = 8'h00;
    int          done_cnt = 0, cyc = 0, go_cyc = 0, done_cyc = 0;
    logic        ack_at_done = 1'b0;
    logic [7:0]  rd_at_done = '0;

    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (!Rst_n) begin
            td_cnt     = 0;
            Trans_Done = 1'b0;
            ack_o      = 1'b0;
        end else begin
            Trans_Done = 1'b0;
            ack_o      = 1'b0;
            if (RW_Done) begin
                done_cnt    = done_cnt + 1;
                done_cyc    = cyc;
                ack_at_done = ack_err;
                rd_at_done  = rddata;
            end
            if (td_cnt > 0) begin
                td_cnt = td_cnt - 1;
                if (td_cnt == 0) begin
                    Trans_Done = 1'b1;
                    ack_o      = (cur_idx == nack_idx);
                    Rx_DATA    = slave_rd;
                end
            end
            if (Go) begin
                log_q.push_back({Cmd, Tx_DATA});
                cur_idx = log_q.size() - 1;
                go_cyc  = cyc;
                if (resp_en) td_cnt = LAT;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic rd, input logic mode,
                          input logic [15:0] a, input logic [7:0] wd, input logic [7:0] id);
        @(negedge Clk);
        wrreg_req = wr; rdreg_req = rd; addr_mode = mode;
        addr = a; wrdata = wd; device_id = id;
        @(negedge Clk);
        wrreg_req = 1'b0; rdreg_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge Clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (done_cnt == start) begin
            errors = errors + 1;
            $error("FAIL %s_timeout observed no RW_Done expected RW_Done within %0d", tag, budget);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [13:0] exp);
        logic [13:0] v;
        v = (idx < log_q.size()) ? log_q[idx] : 14'h3FFF;
        chk(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_go", 32'(Go), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cmd", 32'(Cmd), 32'h0);
        chk("rst_tx", 32'(Tx_DATA), 32'h0);
        chk("rst_rddata", 32'(rddata), 32'h0);
        chk("rst_done", 32'(RW_Done), 32'h0);
        chk("rst_ackerr", 32'(ack_err), 32'h0);
        Rst_n = 1'b1;

        // 1: 16-bit write
        log_q.delete();
        do_req(1'b1, 1'b0, 1'b1, 16'h1234, 8'h5A, 8'hA0);
        chk("t1_busy", 32'(busy), 32'h1);
        wait_done("t1", 200);
        chk("t1_nsteps", 32'(log_q.size()), 32'd4);
        chk_log("t1_s0", 0, {6'h03, 8'hA0});
        chk_log("t1_s1", 1, {6'h01, 8'h12});
        chk_log("t1_s2", 2, {6'h01, 8'h34});
        chk_log("t1_s3", 3, {6'h09, 8'h5A});
        chk("t1_ackerr", 32'(ack_at_done), 32'h0);
        @(negedge Clk); #1;
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_ndone", 32'(done_cnt), 32'd1);

        // 2: 8-bit read
        log_q.delete();
        slave_rd = 8'hC3;
        do_req(1'b0, 1'b1, 1'b0, 16'h0042, 8'h00, 8'h78);
        wait_done("t2", 200);
        chk("t2_nsteps", 32'(log_q.size()), 32'd4);
        chk_log("t2_s0", 0, {6'h03, 8'h78});
        chk_log("t2_s1", 1, {6'h01, 8'h42});
        chk_log("t2_s2", 2, {6'h03, 8'h79});
        chk("t2_s3_cmd", 32'(log_q.size() > 3 ? log_q[3][13:8] : 6'h3F), 32'h2C);
        chk("t2_rddata", 32'(rd_at_done), 32'hC3);
        chk("t2_ackerr", 32'(ack_at_done), 32'h0);

        // 3: NACK on address-high byte, sequence still completes
        log_q.delete();
        nack_idx = 1;
        do_req(1'b1, 1'b0, 1'b1, 16'h1234, 8'h5A, 8'hA0);
        wait_done("t3", 200);
        nack_idx = -1;
        chk("t3_nsteps", 32'(log_q.size()), 32'd4);
        chk_log("t3_s3", 3, {6'h09, 8'h5A});
        chk("t3_ackerr", 32'(ack_at_done), 32'h1);

        // 4: simultaneous requests -> write; read pulse while busy ignored
        log_q.delete();
        do_req(1'b1, 1'b1, 1'b0, 16'h0010, 8'hE7, 8'h30);
        repeat (4) @(negedge Clk);
        rdreg_req = 1'b1;
        @(negedge Clk);
        rdreg_req = 1'b0;
        wait_done("t4", 200);
        chk("t4_ackerr_cleared", 32'(ack_at_done), 32'h0);
        repeat (10) @(negedge Clk);
        chk("t4_nsteps", 32'(log_q.size()), 32'd3);
        chk_log("t4_s0", 0, {6'h03, 8'h30});
        chk_log("t4_s2", 2, {6'h09, 8'hE7});
        chk("t4_idle", 32'(busy), 32'h0);

        // 5: timeout with Trans_Done withheld
        log_q.delete();
        resp_en = 1'b0;
        do_req(1'b1, 1'b0, 1'b0, 16'h0055, 8'h66, 8'hA0);
        wait_done("t5", 300);
        resp_en = 1'b1;
        chk("t5_latency", 32'(done_cyc - go_cyc), 32'd100);
        chk("t5_ackerr", 32'(ack_at_done), 32'h1);
        chk("t5_nsteps", 32'(log_q.size()), 32'd1);
        chk("t5_rddata_held", 32'(rddata), 32'hC3);

        // 6: reset in the middle of a read
        log_q.delete();
        do_req(1'b0, 1'b1, 1'b1, 16'hBEEF, 8'h00, 8'h78);
        begin
            int n;
            n = 0;
            while (log_q.size() < 2 && n < 100) begin
                @(negedge Clk);
                n = n + 1;
            end
        end
        chk("t6_reached_step2", 32'(log_q.size()), 32'd2);
        Rst_n = 1'b0;
        #1;
        chk("t6_go", 32'(Go), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_cmd", 32'(Cmd), 32'h0);
        chk("t6_rddata", 32'(rddata), 32'h0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        log_q.delete();
        do_req(1'b1, 1'b0, 1'b0, 16'h0007, 8'h11, 8'h42);
        wait_done("t6w", 200);
        chk("t6w_nsteps", 32'(log_q.size()), 32'd3);
        chk_log("t6w_s0", 0, {6'h03, 8'h42});
        chk_log("t6w_s1", 1, {6'h01, 8'h07});
        chk_log("t6w_s2", 2, {6'h09, 8'h11});
        chk("t6w_ackerr", 32'(ack_at_done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
